uart_rx_operand: RTL and testbench
==================================

// Module: uart_rx_operand
// PURPOSE
//  UART receiver: the receive side of the serial link the sum/latch system transmits on.
//  Deserialises 8N1 frames (8O1/8E1 with parity option) from uart_rxd.
//  Holds each received byte in an output register with a valid/ack handshake.
//  Flags framing, parity and overrun errors.
//  Low nibble of rx_data feeds operand load (data_input path); full byte available to host logic.
// PARAMETERS
//  CLK_FREQ   10_000_000  system clock frequency, Hz
//  BAUD_RATE  9_600       line bit rate
//  CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer truncation, localparam, must be >= 4)
//  HALF_BIT     = CLKS_PER_BIT/2 (localparam)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-high reset
//  uart_rxd    in   1  serial input, idle high, asynchronous to clk
//  rx_data     out  8  last received byte, LSB received first
//  rx_valid    out  1  high while rx_data holds an unacknowledged byte
//  rx_ack      in   1  consumer strobe; clears rx_valid
//  rx_busy     out  1  high while a frame is being received (state != IDLE)
//  frame_err   out  1  sticky: stop bit sampled low
//  overrun_err out  1  sticky: new byte completed while rx_valid still high
//  parity_err  out  1  sticky: parity mismatch (constant 0 without UART_PARITY_EN)
//  err_clr     in   1  one-cycle strobe clears all three sticky error flags
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser flops preset to 1 (idle line).
//  uart_rxd passes a 2-FF synchroniser; all decisions use the synchronised value rxs.
//  FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; bit_cnt 0..7, clk_cnt 0..CLKS_PER_BIT-1.
//  IDLE:   on rxs==0, clear clk_cnt, go START.
//  START:  at clk_cnt==HALF_BIT-1 resample; rxs==1 -> glitch, back to IDLE, no flags;
//          rxs==0 -> clk_cnt=0, go DATA. All later samples fall at bit centres.
//  DATA:   every CLKS_PER_BIT clocks shift rxs into shreg MSB (right shift); after bit 7 go
//          PARITY if UART_PARITY_EN, else STOP.
//  PARITY: sample one bit; mismatch against configured parity sets parity_err on STOP exit.
//  STOP:   sample at bit centre. rxs==1: commit. rxs==0: set frame_err, byte discarded
//          (rx_data/rx_valid unchanged). Either way go IDLE the same cycle; a stop-low line
//          re-arms only after rxs returns high for >= 1 clk (no false start from a break).
//  Commit (cycle after stop-bit sample): rx_data<=shreg, rx_valid<=1.
//   If rx_valid already 1 and rx_ack not asserted that cycle: overrun_err<=1, rx_data
//   overwritten with newest byte, rx_valid stays 1.
//  Handshake: rx_ack while rx_valid -> rx_valid 0 next cycle; rx_ack while rx_valid 0 ignored.
//   Commit and rx_ack same cycle: commit wins, rx_valid stays 1, no overrun.
//  err_clr and a new error in the same cycle: error set wins.
//  Parity-failed bytes still commit (consumer decides via parity_err).
//  Latency: rx_valid rises 1 clk after stop-bit centre, ~9.5 bit times after start edge (8N1).
//  reset mid-frame: immediate return to IDLE, partial byte lost.
// CONFIGURATION
//  UART_PARITY_EN defined: one parity bit after data; localparam PARITY_ODD (default 0 = even).
//   parity_err is a live sticky flag.
//  UART_PARITY_EN undefined: no PARITY state, frame is 8N1, parity_err tied 0.
// TESTING  (bench: CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> 16 clk/bit)
//  1 Send 0xA5 8N1, ack 2 clk after rx_valid -> rx_data=0xA5, rx_valid 1 clk after stop centre,
//    drops the cycle after ack; no error flags.
//  2 Low pulse of 5 clk on idle line -> stays/returns IDLE, rx_valid 0, all flags 0.
//  3 Send 0x3C with stop bit 0 -> frame_err=1, rx_data unchanged, rx_valid 0;
//    err_clr -> frame_err=0.
//  4 Send 0x11 then 0x22 back-to-back, no ack -> rx_data=0x22, rx_valid=1, overrun_err=1.
//  5 Assert reset during data bit 4 of 0xFF, release, send 0x5A -> rx_data=0x5A, no flags.
//  6 (UART_PARITY_EN, even) send 0x07 with parity bit 0 -> rx_data=0x07, rx_valid=1,
//    parity_err=1; with parity bit 1 -> parity_err stays 0.

Source files
------------

// File: rtl/uart_rx_operand.sv
// UART receiver: 8N1 deserialiser with a valid/ack output register and sticky error flags.
// Optional feature macro: UART_PARITY_EN adds one parity bit per frame (even unless PARITY_ODD is set).
module uart_rx_operand #(
   parameter int CLK_FREQ  = 10_000_000,
   parameter int BAUD_RATE = 9_600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err,
   input  logic       err_clr
);

   // CLKS_PER_BIT must be at least 4 so that the half-bit start check is meaningful.
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

`ifdef UART_PARITY_EN
   localparam logic PARITY_ODD = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_q;
   logic             sync1_q;
   logic             rxs_q;
   logic             armed_q;
   logic [CNT_W-1:0] clk_cnt_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shreg_q;
   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic             frame_err_q;
   logic             overrun_err_q;
`ifdef UART_PARITY_EN
   logic             par_bit_q;
   logic             parity_err_q;
`endif

   // Single FSM block; later assignments deliberately override earlier ones so that
   // a commit beats a same-cycle ack and a new error beats a same-cycle err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= 1'b1;
         rxs_q         <= 1'b1;
         armed_q       <= 1'b1;
         state_q       <= IDLE;
         clk_cnt_q     <= '0;
         bit_cnt_q     <= '0;
         shreg_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
`ifdef UART_PARITY_EN
         par_bit_q     <= 1'b0;
         parity_err_q  <= 1'b0;
`endif
      end else begin
         sync1_q <= uart_rxd;
         rxs_q   <= sync1_q;

         if (err_clr) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
         end

         if (rx_ack && rx_valid_q) begin
            rx_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               clk_cnt_q <= '0;
               bit_cnt_q <= '0;
               // A break left over from a framing error must go high before a new start counts.
               if (rxs_q) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  state_q <= START;
               end
            end

            START: begin
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= rxs_q ? IDLE : DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  shreg_q   <= {rxs_q, shreg_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  par_bit_q <= rxs_q;
                  state_q   <= STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
`endif

            STOP: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  state_q   <= IDLE;
                  if (rxs_q) begin
                     rx_data_q  <= shreg_q;
                     rx_valid_q <= 1'b1;
                     if (rx_valid_q && !rx_ack) begin
                        overrun_err_q <= 1'b1;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     armed_q     <= 1'b0;
                  end
`ifdef UART_PARITY_EN
                  if ((^shreg_q ^ par_bit_q) != PARITY_ODD) begin
                     parity_err_q <= 1'b1;
                  end
`endif
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_busy     = (state_q != IDLE);
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;
`ifdef UART_PARITY_EN
   assign parity_err  = parity_err_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_operand.sv
// Bench for uart_rx_operand at 16 clocks per bit: directed corner cases, a vector table,
// and random frames checked against a frame-level model of the receiver's output register.
module tb_uart_rx_operand;

   localparam int CLK_FREQ  = 1_600_000;
   localparam int BAUD_RATE = 100_000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;

   logic       clk;
   logic       reset;
   logic       uartRxd;
   logic [7:0] rxData;
   logic       rxValid;
   logic       rxAck;
   logic       rxBusy;
   logic       frameErr;
   logic       overrunErr;
   logic       parityErr;
   logic       errClr;

   int total = 0;
   int bad   = 0;

   // Frame-level model of what the consumer should see.
   logic [7:0] mData;
   logic       mValid;
   logic       mFrame;
   logic       mOver;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      logic       ackAfter;
      logic       clrAfter;
      logic [7:0] expData;
      logic       expValid;
      logic       expFrame;
      logic       expOverrun;
   } vec_t;

   vec_t vecs[6];

   uart_rx_operand #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .uart_rxd   (uartRxd),
      .rx_data    (rxData),
      .rx_valid   (rxValid),
      .rx_ack     (rxAck),
      .rx_busy    (rxBusy),
      .frame_err  (frameErr),
      .overrun_err(overrunErr),
      .parity_err (parityErr),
      .err_clr    (errClr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic b);
      uartRxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Drives one full frame; returns at a negedge with the line idle high.
   task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parBit);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) begin
         sendBit(d[i]);
      end
`ifdef UART_PARITY_EN
      sendBit(parBit);
`else
      if (parBit === 1'bx) $display("[TB] note: undefined parity argument");
`endif
      sendBit(stopBit);
      uartRxd = 1'b1;
   endtask

   task automatic pulseAck();
      rxAck = 1'b1;
      @(negedge clk);
      rxAck = 1'b0;
   endtask

   task automatic pulseClr();
      errClr = 1'b1;
      @(negedge clk);
      errClr = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      sendFrame(v.data, v.stopBit, ^v.data);
      repeat (4) @(negedge clk);
      checkOutput($sformatf("vec%0d data", idx), 32'(rxData), 32'(v.expData));
      checkOutput($sformatf("vec%0d valid", idx), 32'(rxValid), 32'(v.expValid));
      checkOutput($sformatf("vec%0d frame_err", idx), 32'(frameErr), 32'(v.expFrame));
      checkOutput($sformatf("vec%0d overrun_err", idx), 32'(overrunErr), 32'(v.expOverrun));
      if (v.ackAfter) pulseAck();
      if (v.clrAfter) pulseClr();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int riseCycle;
      logic [7:0] d;
      logic       stopOk;
      int         action;

      vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1};

      reset   = 1'b1;
      uartRxd = 1'b1;
      rxAck   = 1'b0;
      errClr  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset data", 32'(rxData), 32'h0);
      checkOutput("reset valid", 32'(rxValid), 32'h0);
      checkOutput("reset busy", 32'(rxBusy), 32'h0);
      checkOutput("reset flags", 32'({frameErr, overrunErr, parityErr}), 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Basic frame with latency and ack timing.
      riseCycle = -1;
      fork
         sendFrame(8'hA5, 1'b1, ^8'hA5);
         begin
            for (int c = 1; c <= 300 && riseCycle < 0; c++) begin
               @(negedge clk);
               if (rxValid) riseCycle = c;
            end
         end
      join
      checkOutput("A5 rise in window", 32'(riseCycle >= 152 && riseCycle <= 158), 32'h1);
      checkOutput("A5 data", 32'(rxData), 32'hA5);
      @(negedge clk);
      checkOutput("A5 valid before ack", 32'(rxValid), 32'h1);
      pulseAck();
      checkOutput("A5 valid after ack", 32'(rxValid), 32'h0);
      checkOutput("A5 flags", 32'({frameErr, overrunErr, parityErr}), 32'h0);

      // Short glitch on an idle line.
      uartRxd = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("glitch busy", 32'(rxBusy), 32'h1);
      uartRxd = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("glitch idle", 32'(rxBusy), 32'h0);
      checkOutput("glitch valid", 32'(rxValid), 32'h0);
      checkOutput("glitch flags", 32'({frameErr, overrunErr, parityErr}), 32'h0);

      // Stop bit low.
      sendFrame(8'h3C, 1'b0, ^8'h3C);
      repeat (4) @(negedge clk);
      checkOutput("ferr flag", 32'(frameErr), 32'h1);
      checkOutput("ferr data kept", 32'(rxData), 32'hA5);
      checkOutput("ferr valid", 32'(rxValid), 32'h0);
      pulseClr();
      checkOutput("ferr cleared", 32'(frameErr), 32'h0);

      // Back-to-back without ack.
      sendFrame(8'h11, 1'b1, ^8'h11);
      sendFrame(8'h22, 1'b1, ^8'h22);
      repeat (4) @(negedge clk);
      checkOutput("ovr data", 32'(rxData), 32'h22);
      checkOutput("ovr valid", 32'(rxValid), 32'h1);
      checkOutput("ovr flag", 32'(overrunErr), 32'h1);
      pulseAck();
      pulseClr();

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Reset in the middle of data bit 4.
      uartRxd = 1'b0;
      repeat (CPB) @(negedge clk);
      uartRxd = 1'b1;
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      checkOutput("midframe busy", 32'(rxBusy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midframe reset busy", 32'(rxBusy), 32'h0);
      checkOutput("midframe reset data", 32'(rxData), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      sendFrame(8'h5A, 1'b1, ^8'h5A);
      repeat (4) @(negedge clk);
      checkOutput("post reset data", 32'(rxData), 32'h5A);
      checkOutput("post reset valid", 32'(rxValid), 32'h1);
      checkOutput("post reset flags", 32'({frameErr, overrunErr, parityErr}), 32'h0);
      pulseAck();

      // Random frames against the model.
      mData  = 8'h5A;
      mValid = 1'b0;
      mFrame = 1'b0;
      mOver  = 1'b0;
      for (int n = 0; n < 30; n++) begin
         d      = 8'($urandom);
         stopOk = ($urandom_range(0, 7) != 0);
         sendFrame(d, stopOk, ^d);
         if (stopOk) begin
            if (mValid) mOver = 1'b1;
            mData  = d;
            mValid = 1'b1;
         end else begin
            mFrame = 1'b1;
         end
         repeat (3) @(negedge clk);
         checkOutput($sformatf("rnd%0d data", n), 32'(rxData), 32'(mData));
         checkOutput($sformatf("rnd%0d valid", n), 32'(rxValid), 32'(mValid));
         checkOutput($sformatf("rnd%0d frame_err", n), 32'(frameErr), 32'(mFrame));
         checkOutput($sformatf("rnd%0d overrun_err", n), 32'(overrunErr), 32'(mOver));
         action = $urandom_range(0, 3);
         if (action == 0 || action == 2) begin
            pulseAck();
            mValid = 1'b0;
         end
         if (action == 1 || action == 2) begin
            pulseClr();
            mFrame = 1'b0;
            mOver  = 1'b0;
         end
         repeat (2) @(negedge clk);
      end

`ifdef UART_PARITY_EN
      pulseAck();
      pulseClr();
      sendFrame(8'h07, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("par bad data", 32'(rxData), 32'h07);
      checkOutput("par bad valid", 32'(rxValid), 32'h1);
      checkOutput("par bad flag", 32'(parityErr), 32'h1);
      pulseAck();
      pulseClr();
      sendFrame(8'h07, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("par good flag", 32'(parityErr), 32'h0);
      checkOutput("par good data", 32'(rxData), 32'h07);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
